// File: rtl/rf_pkg.sv
// Shared types and default widths for the multi-port integer register file.
package rf_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]           xlen_t;

  // Width of a port-index field; never zero so a single-port build still has a select bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_write_arb.sv
// Per-register write arbiter: for every register, flags a committing write and picks the
// highest-indexed write port addressing it. Shared by the array update and the read bypass.
module rf_write_arb
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NW    = 2,
  parameter int unsigned SW    = 1
) (
  input  logic                       stall_i,
  input  logic [NW-1:0]              wr_en_i,
  input  logic [NW-1:0][AW-1:0]      wr_addr_i,
  output logic [NREGS-1:0]           reg_we_o,
  output logic [NREGS-1:0][SW-1:0]   reg_sel_o
);

  // Ascending port scan so the last (highest) matching port overrides lower ones; x0 skipped.
  always_comb begin
    reg_we_o  = '0;
    reg_sel_o = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (!stall_i && wr_en_i[k] && (wr_addr_i[k] == AW'(r))) begin
          reg_we_o[r]  = 1'b1;
          reg_sel_o[r] = SW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// NR combinational read ports, NW write ports (highest port wins on the same address),
// NI issue ports that mark destinations busy. x0 reads zero and is never busy.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle committing writes to the read ports.
module regfile_mp #(
  parameter int unsigned XLEN  = rf_pkg::XLEN,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NR    = 4,
  parameter int unsigned NW    = 2,
  parameter int unsigned NI    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic [NW-1:0]            wr_en_i,
  input  logic [NW-1:0][AW-1:0]    wr_addr_i,
  input  logic [NW-1:0][XLEN-1:0]  wr_data_i,
  input  logic [NR-1:0][AW-1:0]    rd_addr_i,
  output logic [NR-1:0][XLEN-1:0]  rd_data_o,
  output logic [NR-1:0]            rd_busy_o,
  input  logic [NI-1:0]            iss_en_i,
  input  logic [NI-1:0][AW-1:0]    iss_addr_i
);

  import rf_pkg::*;

  localparam int unsigned SW = idx_width(NW);

  logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [NREGS-1:0]           busy_set;
  logic [NREGS-1:0]           reg_we;
  logic [NREGS-1:0][SW-1:0]   reg_sel;

  rf_write_arb #(
    .NREGS (NREGS),
    .AW    (AW),
    .NW    (NW),
    .SW    (SW)
  ) u_write_arb (
    .stall_i   (stall_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .reg_we_o  (reg_we),
    .reg_sel_o (reg_sel)
  );

  // Decode issue ports into per-register busy-set requests; duplicates simply OR together.
  always_comb begin
    busy_set = '0;
    for (int unsigned j = 0; j < NI; j++) begin
      if (iss_en_i[j] && !stall_i && (iss_addr_i[j] != '0)) begin
        busy_set[iss_addr_i[j]] = 1'b1;
      end
    end
  end

  // Next array contents from the arbitrated writes.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (reg_we[r]) begin
        mem_d[r] = wr_data_i[reg_sel[r]];
      end
    end
  end

  // Writeback clears busy, a same-cycle issue re-sets it (new producer supersedes the old).
  always_comb begin
    busy_d    = (busy_q & ~reg_we) | busy_set;
    busy_d[0] = 1'b0;
  end

  // Array and scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; entry 0 is never written so x0 reads 0 and not busy.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      rd_data_o[i] = mem_q[rd_addr_i[i]];
      rd_busy_o[i] = busy_q[rd_addr_i[i]];
`ifdef REGFILE_BYPASS_EN
      if (reg_we[rd_addr_i[i]]) begin
        rd_data_o[i] = wr_data_i[reg_sel[rd_addr_i[i]]];
        rd_busy_o[i] = busy_set[rd_addr_i[i]];
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: table of one-cycle vectors plus hand-written
// sequences for reset, same-cycle visibility and mid-run reset.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NR   = 4;
  localparam int unsigned NW   = 2;
  localparam int unsigned NI   = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic                     stall_i;
  logic [NW-1:0]            wr_en_i;
  logic [NW-1:0][AW-1:0]    wr_addr_i;
  logic [NW-1:0][XLEN-1:0]  wr_data_i;
  logic [NR-1:0][AW-1:0]    rd_addr_i;
  logic [NR-1:0][XLEN-1:0]  rd_data_o;
  logic [NR-1:0]            rd_busy_o;
  logic [NI-1:0]            iss_en_i;
  logic [NI-1:0][AW-1:0]    iss_addr_i;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (32),
    .AW    (AW),
    .NR    (NR),
    .NW    (NW),
    .NI    (NI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]             we;
    logic [1:0][AW-1:0]     wa;
    logic [1:0][XLEN-1:0]   wd;
    logic [1:0]             ie;
    logic [1:0][AW-1:0]     ia;
    logic                   st;
    logic [3:0][AW-1:0]     ra;
    logic [3:0][XLEN-1:0]   ed;
    logic [3:0]             eb;
  } vec_t;

  int total;
  int bad;

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    stall_i    = 1'b0;
    wr_en_i    = '0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    iss_en_i   = '0;
    iss_addr_i = '0;
  endtask

  // One clock edge, then drop all write/issue requests so reads show stored state only.
  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  function automatic vec_t mk(
    input logic [1:0] we, input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
    input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
    input logic [1:0] ie, input logic [AW-1:0] ia0, input logic [AW-1:0] ia1, input logic st,
    input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
    input logic [AW-1:0] r3,
    input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
    input logic [XLEN-1:0] e3, input logic [3:0] eb);
    vec_t v;
    v.we = we; v.wa[0] = wa0; v.wd[0] = wd0; v.wa[1] = wa1; v.wd[1] = wd1;
    v.ie = ie; v.ia[0] = ia0; v.ia[1] = ia1; v.st = st;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
    v.eb = eb;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();
    rd_addr_i = '0;
    rst = 1'b0;

    // Expected state after each vector's edge. eb bit i is rd_busy_o[i].
    vecs[0]  = mk(2'b01, 10, 256, 0, 0, 2'b00, 0, 0, 0, 10, 13, 0, 5, 256, 0, 0, 0, 4'b0000);
    vecs[1]  = mk(2'b11, 13, 128, 13, 64, 2'b00, 0, 0, 0, 13, 10, 13, 0, 64, 256, 64, 0,
                  4'b0000);
    vecs[2]  = mk(2'b11, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'b11, 0, 0, 0, 0, 0, 10, 13,
                  0, 0, 256, 64, 4'b0000);
    vecs[3]  = mk(2'b01, 5, 7, 0, 0, 2'b01, 6, 0, 1, 5, 6, 10, 13, 0, 0, 256, 64, 4'b0000);
    vecs[4]  = mk(2'b01, 5, 7, 0, 0, 2'b01, 6, 0, 0, 5, 6, 10, 13, 7, 0, 256, 64, 4'b0010);
    vecs[5]  = mk(2'b00, 0, 0, 0, 0, 2'b01, 7, 0, 0, 7, 6, 5, 0, 0, 0, 7, 0, 4'b0011);
    vecs[6]  = mk(2'b01, 7, 32'h77, 0, 0, 2'b10, 0, 7, 0, 7, 6, 5, 0, 32'h77, 0, 7, 0,
                  4'b0011);
    vecs[7]  = mk(2'b10, 0, 0, 7, 32'h88, 2'b00, 0, 0, 0, 7, 6, 5, 0, 32'h88, 0, 7, 0,
                  4'b0010);
    vecs[8]  = mk(2'b11, 6, 1, 20, 2, 2'b11, 21, 21, 0, 6, 20, 21, 7, 1, 2, 0, 32'h88,
                  4'b0100);
    vecs[9]  = mk(2'b11, 22, 4, 21, 3, 2'b00, 0, 0, 0, 21, 22, 6, 31, 3, 4, 1, 0, 4'b0000);
    vecs[10] = mk(2'b11, 22, 9, 10, 9, 2'b01, 22, 0, 1, 22, 10, 21, 6, 4, 256, 3, 1,
                  4'b0000);

    // Reset held: every address reads 0 and not busy on every port.
    #2;
    for (int a = 0; a < 32; a++) begin
      for (int i = 0; i < NR; i++) rd_addr_i[i] = AW'(a);
      #1;
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("rst_data a%0d p%0d", a, i), rd_data_o[i], '0);
        chk($sformatf("rst_busy a%0d p%0d", a, i), {31'd0, rd_busy_o[i]}, '0);
      end
    end
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors.
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      stall_i    = vecs[n].st;
      wr_en_i    = vecs[n].we;
      wr_addr_i  = vecs[n].wa;
      wr_data_i  = vecs[n].wd;
      iss_en_i   = vecs[n].ie;
      iss_addr_i = vecs[n].ia;
      rd_addr_i  = vecs[n].ra;
      step();
      #1;
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("vec%0d data p%0d", n, i), rd_data_o[i], vecs[n].ed[i]);
        chk($sformatf("vec%0d busy p%0d", n, i), {31'd0, rd_busy_o[i]}, {31'd0, vecs[n].eb[i]});
      end
    end

    // Same-cycle visibility of a write (x11) and of a writeback clearing busy (x9).
    @(negedge clk);
    iss_en_i = 2'b01; iss_addr_i[0] = 9;
    rd_addr_i = '0; rd_addr_i[0] = 9; rd_addr_i[1] = 11;
    step();
    #1;
    chk("x9 busy after issue", {31'd0, rd_busy_o[0]}, 32'd1);
    @(negedge clk);
    wr_en_i = 2'b11; wr_addr_i[0] = 9; wr_data_i[0] = 32'h99;
    wr_addr_i[1] = 11; wr_data_i[1] = 32'h55;
    #1;
    chk("x9 same-cycle data", rd_data_o[0], Byp ? 32'h99 : 32'h0);
    chk("x9 same-cycle busy", {31'd0, rd_busy_o[0]}, Byp ? 32'd0 : 32'd1);
    chk("x11 same-cycle data", rd_data_o[1], Byp ? 32'h55 : 32'h0);
    step();
    #1;
    chk("x9 next-cycle data", rd_data_o[0], 32'h99);
    chk("x9 next-cycle busy", {31'd0, rd_busy_o[0]}, 32'd0);
    chk("x11 next-cycle data", rd_data_o[1], 32'h55);

    // Mid-run reset: busy x25, then pulse rst low between edges.
    @(negedge clk);
    iss_en_i = 2'b01; iss_addr_i[0] = 25;
    rd_addr_i[0] = 10; rd_addr_i[1] = 13; rd_addr_i[2] = 25; rd_addr_i[3] = 5;
    step();
    #1;
    chk("x25 busy before reset", {31'd0, rd_busy_o[2]}, 32'd1);
    chk("x10 before reset", rd_data_o[0], 32'd256);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("midrst data p%0d", i), rd_data_o[i], '0);
      chk($sformatf("midrst busy p%0d", i), {31'd0, rd_busy_o[i]}, '0);
    end
    @(negedge clk);
    rst = 1'b1;
    wr_en_i = 2'b01; wr_addr_i[0] = 10; wr_data_i[0] = 32'h1234;
    step();
    #1;
    chk("first write after reset", rd_data_o[0], 32'h1234);
    chk("x13 stays cleared", rd_data_o[1], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

endmodule
